// File: rtl/ysyx_041514_csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR register file.
// Holds the CSR address map, mstatus/mie/mip bit positions, write masks,
// the read-only misa value, trap cause codes, and helpers that decode a CSR
// address and apply the per-register write mask.
package ysyx_041514_csr_regfile_pkg;

   localparam int unsigned XLEN         = 64;
   localparam int unsigned CSR_ADDR_LEN = 12;

   localparam logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0014_1101;

   // CSR address map
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MSTATUS  = 12'h300;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MISA     = 12'h301;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MIE      = 12'h304;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MTVEC    = 12'h305;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MSCRATCH = 12'h340;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MEPC     = 12'h341;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MCAUSE   = 12'h342;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MIP      = 12'h344;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MINSTRET = 12'hB02;
   localparam logic [CSR_ADDR_LEN-1:0] CSR_MHARTID  = 12'hF14;

   // Bit positions
   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned MIE_MTIE_BIT     = 7;
   localparam int unsigned MIP_MTIP_BIT     = 7;

   // Write masks and hardwired fields
   localparam logic [XLEN-1:0] MSTATUS_WMASK   = 64'h0000_0000_0000_0088;
   localparam logic [XLEN-1:0] MSTATUS_MPP_VAL = 64'h0000_0000_0000_1800;
   localparam logic [XLEN-1:0] MSTATUS_RST     = 64'h0000_0000_0000_1800;
   localparam logic [XLEN-1:0] MIE_WMASK       = 64'h0000_0000_0000_0080;
   localparam logic [XLEN-1:0] MTVEC_WMASK     = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [XLEN-1:0] MEPC_WMASK      = 64'hFFFF_FFFF_FFFF_FFFE;

   // Trap cause codes
   localparam logic [XLEN-1:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
   localparam logic [XLEN-1:0] CAUSE_ECALL_M = 64'd11;

   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_MSTATUS,
      SEL_MISA,
      SEL_MIE,
      SEL_MTVEC,
      SEL_MSCRATCH,
      SEL_MEPC,
      SEL_MCAUSE,
      SEL_MIP,
      SEL_MCYCLE,
      SEL_MINSTRET,
      SEL_MHARTID
   } csr_sel_e;

   // Map a CSR address onto the implemented register it selects.
   function automatic csr_sel_e csr_decode(logic [CSR_ADDR_LEN-1:0] addr);
      case (addr)
         CSR_MSTATUS:  return SEL_MSTATUS;
         CSR_MISA:     return SEL_MISA;
         CSR_MIE:      return SEL_MIE;
         CSR_MTVEC:    return SEL_MTVEC;
         CSR_MSCRATCH: return SEL_MSCRATCH;
         CSR_MEPC:     return SEL_MEPC;
         CSR_MCAUSE:   return SEL_MCAUSE;
         CSR_MIP:      return SEL_MIP;
         CSR_MCYCLE:   return SEL_MCYCLE;
         CSR_MINSTRET: return SEL_MINSTRET;
         CSR_MHARTID:  return SEL_MHARTID;
         default:      return SEL_NONE;
      endcase
   endfunction

   // Top two address bits set marks a read-only CSR.
   function automatic logic csr_is_ro(logic [CSR_ADDR_LEN-1:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction

   // Value the selected CSR reads back as after a write of wdata.
   function automatic logic [XLEN-1:0] csr_wview(csr_sel_e sel, logic [XLEN-1:0] wdata);
      case (sel)
         SEL_MSTATUS: return MSTATUS_MPP_VAL | (wdata & MSTATUS_WMASK);
         SEL_MISA:    return MISA_VAL;
         SEL_MIE:     return wdata & MIE_WMASK;
         SEL_MTVEC:   return wdata & MTVEC_WMASK;
         SEL_MEPC:    return wdata & MEPC_WMASK;
         SEL_MIP:     return '0;
         SEL_MHARTID: return '0;
         default:     return wdata;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_041514_csr_regfile_counter.sv
// 64-bit CSR counter (mcycle / minstret) with load taking priority over
// increment; wraps naturally from all-ones to zero.
// Ports: clk, rst (async active-high), inc_en, load_en, load_data, count.
module ysyx_041514_csr_counter #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] count
);

   // Load wins over increment in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load_en) begin
         count <= load_data;
      end else if (inc_en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/ysyx_041514_csr_regfile.sv
// Machine-mode CSR register file.
// Provides the combinational CSR read path for execute, commits CSR writes at
// writeback, owns trap entry/exit state, mcycle/minstret, and timer-interrupt
// pending; drives the trap vector and mret target to fetch redirect.
// Optional macro YSYX_041514_CSR_BYPASS_EN: forwards a same-cycle legal CSR
// write to the read port (except mip and mcycle).
module ysyx_041514_csr_regfile
   import ysyx_041514_csr_regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CSR_ADDR_LEN-1:0] csr_raddr_i,
   output logic [XLEN-1:0]         csr_rdata_o,
   output logic                    csr_rillegal_o,
   input  logic [CSR_ADDR_LEN-1:0] csr_waddr_i,
   input  logic [XLEN-1:0]         csr_wdata_i,
   input  logic                    csr_wen_i,
   output logic                    csr_willegal_o,
   input  logic                    retire_i,
   input  logic                    trap_valid_i,
   input  logic [XLEN-1:0]         trap_cause_i,
   input  logic [XLEN-1:0]         trap_pc_i,
   input  logic                    mret_i,
   input  logic                    timer_irq_i,
   output logic [XLEN-1:0]         trap_vector_o,
   output logic [XLEN-1:0]         mret_pc_o,
   output logic                    irq_pending_o
);

   logic            mstatus_mie;
   logic            mstatus_mpie;
   logic            mie_mtie;
   logic            mip_mtip;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mscratch;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] mcycle;
   logic [XLEN-1:0] minstret;

   csr_sel_e        rsel;
   csr_sel_e        wsel;
   logic            wr_en;
   logic [XLEN-1:0] wview;
   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] rdata_reg;

   assign rsel  = csr_decode(csr_raddr_i);
   assign wsel  = csr_decode(csr_waddr_i);
   assign wview = csr_wview(wsel, csr_wdata_i);

   assign csr_willegal_o = csr_wen_i & ((wsel == SEL_NONE) | csr_is_ro(csr_waddr_i));

   // A CSR write only commits when legal and no trap/mret claims the cycle.
   assign wr_en = csr_wen_i & ~csr_willegal_o & ~trap_valid_i & ~mret_i;

   assign mstatus_val = MSTATUS_MPP_VAL
                      | (XLEN'(mstatus_mpie) << MSTATUS_MPIE_BIT)
                      | (XLEN'(mstatus_mie)  << MSTATUS_MIE_BIT);

   // Read mux from current register state.
   always_comb begin
      rdata_reg      = '0;
      csr_rillegal_o = 1'b0;
      case (rsel)
         SEL_MSTATUS:  rdata_reg = mstatus_val;
         SEL_MISA:     rdata_reg = MISA_VAL;
         SEL_MIE:      rdata_reg = XLEN'(mie_mtie) << MIE_MTIE_BIT;
         SEL_MTVEC:    rdata_reg = mtvec;
         SEL_MSCRATCH: rdata_reg = mscratch;
         SEL_MEPC:     rdata_reg = mepc;
         SEL_MCAUSE:   rdata_reg = mcause;
         SEL_MIP:      rdata_reg = XLEN'(mip_mtip) << MIP_MTIP_BIT;
         SEL_MCYCLE:   rdata_reg = mcycle;
         SEL_MINSTRET: rdata_reg = minstret;
         SEL_MHARTID:  rdata_reg = '0;
         default:      csr_rillegal_o = 1'b1;
      endcase
   end

`ifdef YSYX_041514_CSR_BYPASS_EN
   logic bypass;

   // mip tracks the timer line and mcycle ticks, so neither is forwarded.
   assign bypass = wr_en & (csr_raddr_i == csr_waddr_i)
                 & (wsel != SEL_MIP) & (wsel != SEL_MCYCLE);
   assign csr_rdata_o = bypass ? wview : rdata_reg;
`else
   assign csr_rdata_o = rdata_reg;
`endif

   // Trap / mret / CSR-write state, in that priority order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_mtie     <= 1'b0;
         mip_mtip     <= 1'b0;
         mtvec        <= '0;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
      end else begin
         mip_mtip <= timer_irq_i;
         if (trap_valid_i) begin
            mepc         <= trap_pc_i & MEPC_WMASK;
            mcause       <= trap_cause_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (wr_en) begin
            case (wsel)
               SEL_MSTATUS: begin
                  mstatus_mie  <= wview[MSTATUS_MIE_BIT];
                  mstatus_mpie <= wview[MSTATUS_MPIE_BIT];
               end
               SEL_MIE:      mie_mtie <= wview[MIE_MTIE_BIT];
               SEL_MTVEC:    mtvec    <= wview;
               SEL_MSCRATCH: mscratch <= wview;
               SEL_MEPC:     mepc     <= wview;
               SEL_MCAUSE:   mcause   <= wview;
               default:      ;
            endcase
         end
      end
   end

   ysyx_041514_csr_counter #(.WIDTH(XLEN)) u_mcycle (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (1'b1),
      .load_en   (wr_en & (wsel == SEL_MCYCLE)),
      .load_data (csr_wdata_i),
      .count     (mcycle)
   );

   // A trapping instruction does not retire.
   ysyx_041514_csr_counter #(.WIDTH(XLEN)) u_minstret (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (retire_i & ~trap_valid_i),
      .load_en   (wr_en & (wsel == SEL_MINSTRET)),
      .load_data (csr_wdata_i),
      .count     (minstret)
   );

   assign trap_vector_o = {mtvec[XLEN-1:2], 2'b00};
   assign mret_pc_o     = mepc;
   assign irq_pending_o = mstatus_mie & mie_mtie & mip_mtip;

endmodule
